// File: rtl/bsg_ctrl_pulse_pkg.sv
// Shared types and width helpers for the bsg_ctrl_pulse_gen control-pulse source.
package bsg_ctrl_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        GAP
    } bsg_ctrl_pulse_state_e;

    // Gap counter needs at least one bit even when no dead time is configured.
    function automatic int unsigned gap_cnt_width(input int unsigned gap);
        return (gap <= 1) ? 1 : $clog2(gap);
    endfunction

endpackage

// File: rtl/bsg_ctrl_pulse_slot.sv
// One-entry pending-request holder: a length register plus a full flag.
module bsg_ctrl_pulse_slot #(
    parameter int unsigned width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               wr_i,
    input  logic               clr_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o
);

    logic [width_p-1:0] data_q;
    logic               full_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (clr_i) begin
            full_q <= 1'b0;
        end else if (wr_i) begin
            data_q <= data_i;
            full_q <= 1'b1;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/bsg_ctrl_pulse_gen.sv
// Pulse-request front end for bsg_buf_ctrl: emits a registered control bit held high for
// the requested length, followed by a fixed dead-time gap, with one queued request.
module bsg_ctrl_pulse_gen
    import bsg_ctrl_pulse_pkg::*;
#(
    parameter int unsigned len_width_p = 8,
    parameter int unsigned gap_p       = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    input  logic [len_width_p-1:0] len_i,
    output logic                   ready_o,
    input  logic                   abort_i,
    output logic                   ctrl_o,
    output logic                   done_o,
    output logic                   busy_o
);

    localparam int unsigned GapW = gap_cnt_width(gap_p);
    localparam logic [GapW-1:0] GapLoad = GapW'((gap_p > 0) ? gap_p - 1 : 0);

    bsg_ctrl_pulse_state_e state_q, state_d;
    logic [len_width_p-1:0] cnt_q, cnt_d;
    logic [GapW-1:0]        gap_q, gap_d;
    logic                   ctrl_q, ctrl_d;
    logic                   done_q, done_d;

    logic                   accept;
    logic                   slot_wr, slot_clr, slot_full;
    logic [len_width_p-1:0] slot_len;

    assign ready_o = ~slot_full & ~abort_i & reset_n_i;
    assign accept  = v_i & ready_o;

    bsg_ctrl_pulse_slot #(
        .width_p(len_width_p)
    ) u_slot (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .wr_i     (slot_wr),
        .clr_i    (slot_clr),
        .data_i   (len_i),
        .data_o   (slot_len),
        .full_o   (slot_full)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            ctrl_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            ctrl_q  <= ctrl_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        slot_wr  = 1'b0;
        slot_clr = 1'b0;
        if (abort_i) begin
            state_d  = IDLE;
            slot_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    // A request written on a final cycle can land while returning to idle.
                    if (slot_full) begin
                        state_d  = ACTIVE;
                        cnt_d    = slot_len - len_width_p'(1);
                        slot_clr = 1'b1;
                    end else if (accept) begin
                        state_d = ACTIVE;
                        cnt_d   = len_i - len_width_p'(1);
                    end
                end
                ACTIVE: begin
                    cnt_d   = cnt_q - len_width_p'(1);
                    slot_wr = accept;
                    if (cnt_q == '0) begin
                        if (gap_p > 0) begin
                            state_d = GAP;
                            gap_d   = GapLoad;
                        end else if (slot_full) begin
                            cnt_d    = slot_len - len_width_p'(1);
                            slot_clr = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                GAP: begin
                    gap_d   = gap_q - GapW'(1);
                    slot_wr = accept;
                    if (gap_q == '0) begin
                        if (slot_full) begin
                            state_d  = ACTIVE;
                            cnt_d    = slot_len - len_width_p'(1);
                            slot_clr = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ctrl_d = (state_d == ACTIVE);
        done_d = ~abort_i & (state_q == ACTIVE) & (cnt_q == '0);
    end

    assign ctrl_o = ctrl_q;
    assign done_o = done_q;
    assign busy_o = (state_q != IDLE) | slot_full;

endmodule

// File: tb/tb_bsg_ctrl_pulse_gen.sv
// Directed bench for bsg_ctrl_pulse_gen across gap_p=2, gap_p=0 and len_width_p=4 builds.
module tb_bsg_ctrl_pulse_gen;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Default build: len_width_p=8, gap_p=2
    logic       v0 = 1'b0, ab0 = 1'b0;
    logic [7:0] len0 = '0;
    logic       ready0, ctrl0, done0, busy0;
    // gap_p=0 build
    logic       v1 = 1'b0, ab1 = 1'b0;
    logic [7:0] len1 = '0;
    logic       ready1, ctrl1, done1, busy1;
    // len_width_p=4 build
    logic       v2 = 1'b0, ab2 = 1'b0;
    logic [3:0] len2 = '0;
    logic       ready2, ctrl2, done2, busy2;

    bsg_ctrl_pulse_gen #(.len_width_p(8), .gap_p(2)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v0), .len_i(len0), .ready_o(ready0),
        .abort_i(ab0), .ctrl_o(ctrl0), .done_o(done0), .busy_o(busy0)
    );

    bsg_ctrl_pulse_gen #(.len_width_p(8), .gap_p(0)) dut_g0 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v1), .len_i(len1), .ready_o(ready1),
        .abort_i(ab1), .ctrl_o(ctrl1), .done_o(done1), .busy_o(busy1)
    );

    bsg_ctrl_pulse_gen #(.len_width_p(4), .gap_p(2)) dut_w4 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v2), .len_i(len2), .ready_o(ready2),
        .abort_i(ab2), .ctrl_o(ctrl2), .done_o(done2), .busy_o(busy2)
    );

    // Outputs packed as {ctrl, done, ready, busy}.
    task automatic test_reset();
        logic [3:0] got;
        #12;
        got = {ctrl0, done0, ready0, busy0};
        n_checks++;
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_held: got %b want 0000", got);
        end
        reset_n = 1'b1;
        #1;
        got = {ctrl0, done0, ready0, busy0};
        n_checks++;
        if (got !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_release: got %b want 0010", got);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [3:0] want [8];
        logic [3:0] got;
        want = '{4'b0010, 4'b1011, 4'b1011, 4'b1011, 4'b0111, 4'b0011, 4'b0010, 4'b0010};
        for (int c = 0; c < 8; c++) begin
            v0   = (c == 0);
            len0 = 8'd3;
            @(negedge clk);
            got = {ctrl0, done0, ready0, busy0};
            n_checks++;
            if (got !== want[c]) begin
                n_fail++;
                $display("FAIL single c%0d: got %b want %b", c, got, want[c]);
            end
            @(posedge clk); #1;
        end
        v0 = 1'b0;
    endtask

    task automatic test_queued();
        logic [3:0] want [11];
        logic [3:0] got;
        want = '{4'b0010, 4'b1011, 4'b1001, 4'b1001, 4'b0101, 4'b0001,
                 4'b1011, 4'b1011, 4'b0111, 4'b0011, 4'b0010};
        for (int c = 0; c < 11; c++) begin
            v0   = (c <= 1);
            len0 = (c == 0) ? 8'd3 : 8'd2;
            @(negedge clk);
            got = {ctrl0, done0, ready0, busy0};
            n_checks++;
            if (got !== want[c]) begin
                n_fail++;
                $display("FAIL queued c%0d: got %b want %b", c, got, want[c]);
            end
            @(posedge clk); #1;
        end
        v0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] want [6];
        logic [3:0] got;
        want = '{4'b0010, 4'b1011, 4'b1001, 4'b1111, 4'b0110, 4'b0010};
        for (int c = 0; c < 6; c++) begin
            v1   = (c <= 1);
            len1 = (c == 0) ? 8'd2 : 8'd1;
            @(negedge clk);
            got = {ctrl1, done1, ready1, busy1};
            n_checks++;
            if (got !== want[c]) begin
                n_fail++;
                $display("FAIL merge c%0d: got %b want %b", c, got, want[c]);
            end
            @(posedge clk); #1;
        end
        v1 = 1'b0;
    endtask

    task automatic test_len_wrap();
        int ctrl_cnt = 0, done_cnt = 0, first_hi = -1, last_hi = -1, done_cyc = -1;
        for (int c = 0; c < 23; c++) begin
            v2   = (c == 0);
            len2 = 4'd0;
            @(negedge clk);
            if (ctrl2 === 1'b1) begin
                ctrl_cnt++;
                if (first_hi < 0) first_hi = c;
                last_hi = c;
            end
            if (done2 === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
            @(posedge clk); #1;
        end
        v2 = 1'b0;
        n_checks++;
        if (ctrl_cnt != 16) begin
            n_fail++;
            $display("FAIL wrap_len: got %0d high cycles want 16", ctrl_cnt);
        end
        n_checks++;
        if (first_hi != 1 || last_hi != 16) begin
            n_fail++;
            $display("FAIL wrap_span: got %0d..%0d want 1..16", first_hi, last_hi);
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != 17) begin
            n_fail++;
            $display("FAIL wrap_done: got %0d pulses at c%0d want 1 at c17", done_cnt, done_cyc);
        end
    endtask

    task automatic test_abort();
        logic [3:0] want [16];
        logic [3:0] got;
        want = '{4'b0010, 4'b1011, 4'b1001, 4'b1001, 4'b1001, 4'b0010, 4'b0000, 4'b0010,
                 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
        for (int c = 0; c < 16; c++) begin
            v0   = (c <= 1) || (c == 4);
            len0 = (c == 0) ? 8'd10 : 8'd5;
            ab0  = (c == 4) || (c == 6);
            @(negedge clk);
            got = {ctrl0, done0, ready0, busy0};
            n_checks++;
            if (got !== want[c]) begin
                n_fail++;
                $display("FAIL abort c%0d: got %b want %b", c, got, want[c]);
            end
            @(posedge clk); #1;
        end
        v0  = 1'b0;
        ab0 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] got;
        for (int c = 0; c < 3; c++) begin
            v0   = (c == 0);
            len0 = 8'd5;
            @(negedge clk);
            if (c == 2) begin
                got = {ctrl0, done0, ready0, busy0};
                n_checks++;
                if (got !== 4'b1011) begin
                    n_fail++;
                    $display("FAIL rstmid_pre: got %b want 1011", got);
                end
            end
            if (c < 2) begin
                @(posedge clk); #1;
            end
        end
        v0 = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        got = {ctrl0, done0, ready0, busy0};
        n_checks++;
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_async: got %b want 0000", got);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        got = {ctrl0, done0, ready0, busy0};
        n_checks++;
        if (got !== 4'b0010) begin
            n_fail++;
            $display("FAIL rstmid_release: got %b want 0010", got);
        end
        @(posedge clk); #1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            got = {ctrl0, done0, ready0, busy0};
            n_checks++;
            if (got !== 4'b0010) begin
                n_fail++;
                $display("FAIL rstmid_after c%0d: got %b want 0010", c, got);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_queued();
        test_back_to_back();
        test_len_wrap();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bsg_ctrl_pulse_gen.md
Name: bsg_ctrl_pulse_gen

Overview:
Upstream control source for bsg_buf_ctrl. Accepts pulse requests over a valid/ready handshake and produces a single registered, glitch-free control bit. The bit is asserted for a requested number of cycles, followed by a fixed dead-time gap. A one-entry pending slot allows a second request to queue while a pulse is in progress. ctrl_o drives the i input of the fan-out buffer directly.

Parameters:
len_width_p, 8, width of the pulse-length field; len_i==0 encodes 2^len_width_p cycles
gap_p, 2, dead cycles of ctrl_o low between consecutive pulses; 0 allowed

Ports:
clk_i  input  1  clock
reset_n_i  input  1  asynchronous active-low reset
v_i  input  1  request valid
len_i  input  len_width_p  requested pulse length in cycles
ready_o  output  1  request can be accepted this cycle
abort_i  input  1  synchronous cancel of active and pending work
ctrl_o  output  1  registered control bit to bsg_buf_ctrl
done_o  output  1  one-cycle pulse after each completed (non-aborted) pulse
busy_o  output  1  state != IDLE or slot full

Behaviour:
- Clock and reset: one clock, clk_i. Reset is reset_n_i, asynchronous, active-low.
- Values while reset_n_i low: state=IDLE, ctrl_o=0, done_o=0, slot empty, busy_o=0, ready_o=0.
- Values after reset release: ready_o=1.
- ready_o = ~slot_full & ~abort_i & reset_n_i. No combinational path from v_i.
- Accept: occurs when v_i & ready_o, sampled at a rising edge.
- Accept while IDLE with slot empty (bypass):
  - next state ACTIVE, down-counter loaded with len_i-1, computed modulo 2^len_width_p.
  - ctrl_o is high starting the cycle after accept (latency 1).
- Accept in any other state: the request is written into the slot; ready_o falls next cycle.
- States: IDLE, ACTIVE, GAP.
- ACTIVE:
  - ctrl_o=1; counter decrements each cycle.
  - On the cycle with cnt==0, done_o is registered high for the following cycle.
  - Next state when cnt==0:
    - gap_p>0: GAP, gap counter loaded with gap_p-1.
    - gap_p==0 and slot full: ACTIVE, counter loaded from the slot, slot cleared. ctrl_o stays high continuously.
    - otherwise: IDLE.
- GAP:
  - ctrl_o=0.
  - On the last gap cycle: slot full -> ACTIVE (load from slot, clear slot); otherwise IDLE.
- Slot write and slot clear never coincide, because ready_o=0 while the slot is full.
- Counter width: len_width_p. Gap counter width: max(1, $clog2(gap_p)).
- ctrl_o and done_o come directly from flops. No output depends combinationally on inputs except ready_o (via abort_i).
- abort_i (highest priority, synchronous):
  - next state IDLE, ctrl_o=0 next cycle, slot cleared.
  - done_o for the aborted pulse is suppressed.
  - Any v_i in the abort cycle is not accepted.
- Abort during GAP: the done_o already in flight (the cycle after the last ACTIVE cycle) is not retracted.
- Reset asserted mid-pulse: ctrl_o drops asynchronously; the pending request is lost.

Decomposition:
- Package bsg_ctrl_pulse_pkg holds:
  - typedef enum logic [1:0] bsg_ctrl_pulse_state_e {IDLE, ACTIVE, GAP}
  - localparam helper for gap counter width.
- One natural sub-module: bsg_ctrl_pulse_slot, a one-entry len_width_p register with full flag, write/clear, and async active-low reset.
- Counters and FSM stay in the top module.

Test Plan:
- Single pulse, gap_p=2: len=3 accepted cycle 0 -> ctrl_o=1 cycles 1-3, done_o=1 cycle 4, ctrl_o=0 cycles 4-5, IDLE and busy_o=0 cycle 6.
- Queued request, gap_p=2: len=3 at cycle 0, len=2 at cycle 1 ->
  - ready_o=0 cycles 2-5, ready_o=1 cycle 6
  - ctrl_o=1 cycles 6-7, done_o at 4 and 8.
- Back-to-back merge, gap_p=0: len=2 at cycle 0, len=1 at cycle 1 -> ctrl_o=1 cycles 1-3 with no gap, done_o at 3 and 4.
- Length wrap, len_width_p=4: len=0 -> ctrl_o high exactly 16 cycles, done_o once.
- Abort mid-pulse: len=10 accepted cycle 0, slot loaded, abort_i at cycle 4 -> ctrl_o=0 from cycle 5, no done_o, slot empty, ready_o=1 cycle 5; v_i held during the abort cycle is not accepted.
- Async reset at cycle 2 of a len=5 pulse -> ctrl_o=0 immediately, no done_o, ready_o=1 in the first cycle after reset_n_i rises.
